// File: rtl/div_unit_pkg.sv
// ============================================================================
// Module   : div_unit_pkg
// Purpose  : Shared constants and state encoding for the iterative divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_unit_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    localparam logic [31:0] DIV_BY_ZERO_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

`default_nettype wire

// File: rtl/div_unit_if.sv
// ============================================================================
// Module   : div_unit_if
// Purpose  : Request/response handshake between execute, divider and memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_unit_if #(
    parameter int WIDTH = 32
) ();

    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             div_signed;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output req_valid, dividend, divisor, div_signed, resp_ready,
        input  req_ready, resp_valid, quotient, remainder
    );

    modport slave (
        input  req_valid, dividend, divisor, div_signed, resp_ready,
        output req_ready, resp_valid, quotient, remainder
    );

endinterface

`default_nettype wire

// File: rtl/div_unit_step.sv
// ============================================================================
// Module   : div_step
// Purpose  : One combinational restoring radix-2 division iteration.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    assign w_shift = {rem_in, dvd_msb};
    assign w_diff  = w_shift - {1'b0, divisor};
    assign q_bit   = ~w_diff[WIDTH];
    assign rem_out = q_bit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// Module   : div_unit
// Purpose  : Iterative 32-bit signed/unsigned divider with flush support.
//            Optional DIV_FAST_PATH_EN: single-cycle result for x/0 and |a|<|b|.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    div_unit_if.slave bus
);

    div_state_e       r_state;
    div_state_e       w_state_next;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_q_neg;
    logic             r_r_neg;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic             w_dvs_zero;
    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dvs_abs;
    logic             w_accept;
    logic             w_last;
    logic             w_fast;
    logic [WIDTH-1:0] w_step_rem;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_q_final;

    assign w_dvd_neg  = bus.div_signed & bus.dividend[WIDTH-1];
    assign w_dvs_neg  = bus.div_signed & bus.divisor[WIDTH-1];
    assign w_dvs_zero = (bus.divisor == '0);
    assign w_dvd_abs  = w_dvd_neg ? -bus.dividend : bus.dividend;
    assign w_dvs_abs  = w_dvs_neg ? -bus.divisor  : bus.divisor;

    assign w_accept = (r_state == DIV_IDLE) && bus.req_valid && !flush;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef DIV_FAST_PATH_EN
    assign w_fast = w_dvs_zero || (w_dvd_abs < w_dvs_abs);
`else
    assign w_fast = 1'b0;
`endif

    assign bus.req_ready  = (r_state == DIV_IDLE) && !rst;
    assign bus.resp_valid = (r_state == DIV_DONE);
    assign bus.quotient   = r_quot;
    assign bus.remainder  = r_remd;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (r_rem),
        .dvd_msb (r_dvd[WIDTH-1]),
        .divisor (r_dvs),
        .rem_out (w_step_rem),
        .q_bit   (w_q_bit)
    );

    assign w_q_final = {r_dvd[WIDTH-2:0], w_q_bit};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            DIV_IDLE: if (w_accept) w_state_next = w_fast ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: begin
                if (flush)       w_state_next = DIV_IDLE;
                else if (w_last) w_state_next = DIV_DONE;
            end
            DIV_DONE: if (flush || bus.resp_ready) w_state_next = DIV_IDLE;
            default:  w_state_next = DIV_IDLE;
        endcase
    end

    // The quotient keeps positive sign for x/0 so the all-ones result survives
    // sign correction; the remainder then naturally equals the original dividend.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_cnt   <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_quot  <= '0;
            r_remd  <= '0;
        end else if (w_accept) begin
            r_rem   <= '0;
            r_dvd   <= w_dvd_abs;
            r_dvs   <= w_dvs_abs;
            r_cnt   <= '0;
            r_q_neg <= (w_dvd_neg ^ w_dvs_neg) & ~w_dvs_zero;
            r_r_neg <= w_dvd_neg;
            if (w_fast) begin
                r_quot <= w_dvs_zero ? DIV_BY_ZERO_QUOT : '0;
                r_remd <= bus.dividend;
            end
        end else if ((r_state == DIV_BUSY) && !flush) begin
            r_rem <= w_step_rem;
            r_dvd <= w_q_final;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_quot <= r_q_neg ? -w_q_final : w_q_final;
                r_remd <= r_r_neg ? -w_step_rem : w_step_rem;
            end
        end
    end

endmodule

`default_nettype wire
